skew_combine_pipe: RTL
======================

SKEW_COMBINE_PIPE -- requirements
Module: skew_combine_pipe

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each channel word.
REQ-002 Parameter CHANNELS, default 2, number of input channels (legal 2..8).
REQ-003 Parameter DEPTH, default 3, total pipeline register stages from acceptance to output (legal 2..16).
REQ-004 Parameter CNT_W, default 16, width of the delivered-transaction counter.
REQ-005 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 Port rst  input  1  reset, synchronous, active-high.
REQ-007 Port in_valid  input  1  upstream offers a transaction.
REQ-008 Port in_ready  output  1  block accepts the transaction this cycle.
REQ-009 Port in_data  input  CHANNELS*WIDTH  channel words; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-010 Port in_op  input  2  combine operator: 0 AND, 1 OR, 2 XOR, 3 PASS (channel 0 only).
REQ-011 Port out_valid  output  1  output word is valid.
REQ-012 Port out_ready  input  1  downstream accepts the output word.
REQ-013 Port out_data  output  WIDTH  combined result.
REQ-014 Port out_count  output  CNT_W  number of completed output handshakes.

Function
REQ-015 Transfer on the input SHALL occur in a cycle where in_valid and in_ready are both 1; on the output where out_valid and out_ready are both 1.
REQ-016 Stall SHALL be defined as out_valid=1 and out_ready=0; in_ready SHALL equal not stall (combinational from out_ready).
REQ-017 During stall every pipeline stage (data, op, valid) SHALL hold its value.
REQ-018 Stage 1 SHALL register all raw channel words, in_op and a valid bit (valid = in_valid and in_ready).
REQ-019 The combine SHALL be computed from stage 1 contents and registered into stage 2; stages 3..DEPTH SHALL shift stage contents forward one per non-stalled cycle.
REQ-020 Combine SHALL be bitwise across all CHANNELS words, result WIDTH bits; PASS SHALL output channel 0 unchanged.
REQ-021 out_data and out_valid SHALL be the contents of stage DEPTH.
REQ-022 With no stall, a transaction accepted at edge T SHALL present out_valid=1 after edge T+DEPTH-1 (visible DEPTH cycles after in_valid was sampled) — latency exactly DEPTH.
REQ-023 Bubbles SHALL NOT be collapsed; invalid slots advance like valid ones.
REQ-024 in_op SHALL be captured per transaction; back-to-back transactions with different ops SHALL each use their own op.
REQ-025 Throughput SHALL be one transaction per cycle while out_ready=1.
REQ-026 out_count SHALL increment by 1 per output handshake and wrap from 2^CNT_W-1 to 0.
REQ-027 out_data SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-028 While rst=1 all valid bits, out_valid and out_count SHALL be 0 on the next edge; in_ready SHALL be 1 after reset.
REQ-029 Data/op registers SHALL also reset to 0 so out_data=0 after reset.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight transactions without producing an output handshake.

Structure
REQ-031 Shared package skew_combine_pkg SHALL hold the op enumeration (OP_AND, OP_OR, OP_XOR, OP_PASS) and the combine function.
REQ-032 One sub-module skew_pipe_stage (parametrised data width, enable, sync reset, valid bit) SHALL be instantiated per stage via generate.
REQ-033 No latches, no clock gating, no derived clocks.

Verification (WIDTH=8, CHANNELS=2, DEPTH=3 unless stated)
REQ-034 Reset then single transfer in_data={8'h0F,8'h3C}, op AND, out_ready=1 -> out_valid 3 cycles later, out_data=8'h0C, out_count=1.
REQ-035 Four back-to-back transfers ops AND/OR/XOR/PASS on {8'hF0,8'hAA} -> outputs 8'hA0, 8'hFA, 8'h5A, 8'hAA on consecutive cycles.
REQ-036 out_ready=0 for 5 cycles with full pipe -> in_ready=0, out_data held, no count change; release -> stream resumes in order, no loss or duplication.
REQ-037 rst pulse while 3 transactions in flight -> out_valid=0 next cycle, out_count=0, none delivered afterwards.
REQ-038 CNT_W=4, 17 transfers -> out_count=1 after wrap.
REQ-039 CHANNELS=4, DEPTH=5, XOR of {8'h01,8'h02,8'h04,8'h08} -> 8'h0F after 5 cycles.

Source files
------------

// File: rtl/skew_combine_pkg.sv
// -----------------------------------------------------------------------------
// skew_combine_pkg
// Shared definitions for the skew_combine_pipe block:
//   op_e         - combine operator encoding carried with every transaction
//   MAX_CHANNELS - largest channel count the combine helper supports
//   combine_bit  - combines one bit column (one bit from each channel)
// The combine works one bit column at a time. This lets a single package
// function serve any WIDTH without needing a parametrised function.
// -----------------------------------------------------------------------------
package skew_combine_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_PASS = 2'd3
    } op_e;

    localparam int MAX_CHANNELS = 8;

    // Combine bit b of every active channel. col[c] holds channel c's bit.
    // Entries at or above n are ignored. PASS returns channel 0.
    function automatic logic combine_bit(input op_e                     op,
                                         input logic [MAX_CHANNELS-1:0] col,
                                         input int                      n);
        logic r_and;
        logic r_or;
        logic r_xor;
        logic r;
        r_and = 1'b1;
        r_or  = 1'b0;
        r_xor = 1'b0;
        for (int i = 0; i < MAX_CHANNELS; i++) begin
            if (i < n) begin
                r_and = r_and & col[i];
                r_or  = r_or  | col[i];
                r_xor = r_xor ^ col[i];
            end
        end
        case (op)
            OP_AND:  r = r_and;
            OP_OR:   r = r_or;
            OP_XOR:  r = r_xor;
            OP_PASS: r = col[0];
            default: r = col[0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/skew_pipe_stage.sv
// -----------------------------------------------------------------------------
// skew_pipe_stage
// One pipeline slot. It holds a W-bit payload and a valid bit.
// The slot loads when en=1 and holds when en=0.
// Synchronous active-high reset clears both the payload and the valid bit.
// Ports:
//   clk, rst          clock and synchronous reset
//   en                advance enable (low while the pipe is stalled)
//   valid_i, data_i   contents of the previous slot
//   valid_o, data_o   registered contents of this slot
// -----------------------------------------------------------------------------
module skew_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Slot register: reset clears it, enable loads it, otherwise it holds.
    // Bubbles advance the same way valid words do.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en) begin
            valid_q <= valid_i;
            data_q  <= data_i;
        end else begin
            valid_q <= valid_q;
            data_q  <= data_q;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/skew_combine_pipe.sv
// -----------------------------------------------------------------------------
// skew_combine_pipe
// Accepts CHANNELS words of WIDTH bits plus an operator, and combines them
// bitwise (AND / OR / XOR / PASS channel 0). The result leaves through a
// DEPTH-stage valid/ready pipeline.
//   Stage 1       : raw channel words, op and valid bit
//   Stage 2       : combined result computed from stage 1
//   Stage 3..DEPTH: plain shift
// The whole pipe freezes while the output is stalled. in_ready is the
// inverse of that stall.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              input handshake
//   in_data [CHANNELS*WIDTH]       channel c at [c*WIDTH +: WIDTH]
//   in_op [2]                      operator, captured per transaction
//   out_valid/out_ready            output handshake
//   out_data [WIDTH]               combined word (stage DEPTH)
//   out_count [CNT_W]              wrapping count of output handshakes
// -----------------------------------------------------------------------------
module skew_combine_pipe
    import skew_combine_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [1:0]                in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CNT_W-1:0]          out_count
);

    localparam int S1_W = CHANNELS * WIDTH + 2;

    logic                    stall_s;
    logic                    en_s;
    logic                    s1_valid_s;
    logic [S1_W-1:0]         s1_data_s;
    op_e                     s1_op_s;
    logic [MAX_CHANNELS-1:0] col_s;
    logic [WIDTH-1:0]        comb_s;
    logic [DEPTH:2]          st_valid_s;
    logic [WIDTH-1:0]        st_data_s [2:DEPTH];
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_d;

    assign stall_s  = out_valid & ~out_ready;
    assign en_s     = ~stall_s;
    assign in_ready = ~stall_s;

    assign s1_op_s = op_e'(s1_data_s[S1_W-1 -: 2]);

    // Build one bit column at a time from the stage 1 words, then combine it.
    always_comb begin
        col_s  = '0;
        comb_s = '0;
        for (int b = 0; b < WIDTH; b++) begin
            col_s = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                col_s[c] = s1_data_s[c*WIDTH + b];
            end
            comb_s[b] = combine_bit(s1_op_s, col_s, CHANNELS);
        end
    end

    // One slot per stage. Stage 1 is wide (raw words + op); the rest hold results.
    for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
        if (s == 1) begin : g_first
            skew_pipe_stage #(.W(S1_W)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (en_s),
                .valid_i (in_valid & in_ready),
                .data_i  ({in_op, in_data}),
                .valid_o (s1_valid_s),
                .data_o  (s1_data_s)
            );
        end else if (s == 2) begin : g_comb
            skew_pipe_stage #(.W(WIDTH)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (en_s),
                .valid_i (s1_valid_s),
                .data_i  (comb_s),
                .valid_o (st_valid_s[s]),
                .data_o  (st_data_s[s])
            );
        end else begin : g_shift
            skew_pipe_stage #(.W(WIDTH)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en      (en_s),
                .valid_i (st_valid_s[s-1]),
                .data_i  (st_data_s[s-1]),
                .valid_o (st_valid_s[s]),
                .data_o  (st_data_s[s])
            );
        end
    end

    assign out_valid = st_valid_s[DEPTH];
    assign out_data  = st_data_s[DEPTH];

    // Next value of the delivered counter; it wraps naturally at 2^CNT_W.
    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && out_ready) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Delivered counter register. Reset wins over a same-cycle handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;

endmodule
